// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension divide sequencer: width, funct3 codes, FSM states.
package muldiv_pkg;
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;
endpackage

// File: rtl/div_seq_if.sv
// Issue/result bundle between the execute stage and the divide sequencer.
interface div_seq_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] y;

    modport master (output start, funct3, a, b, flush, input busy, stall, done, y);
    modport slave  (input start, funct3, a, b, flush, output busy, stall, done, y);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring divide step on an XLEN+1 bit trial subtraction.
module div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic [W-1:0] rem,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted  = {rem, q_msb};
    assign diff     = shifted - {1'b0, divisor};
    // A set top bit means the trial went negative: restore.
    assign q_bit    = ~diff[W];
    assign rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: magnitude restoring divide plus sign fix-up.
module div_seq
    import muldiv_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONES = {XLEN{1'b1}};

    div_state_t      state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] divisor;
    logic            op_rem;
    logic            neg_q;
    logic            neg_r;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] y;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            is_zero;
    logic            is_ovf;
    logic            special;
    logic [XLEN-1:0] special_y;
    logic            accept;
    logic [XLEN-1:0] rem_next;
    logic            q_bit;

    // Operand preparation for an op being accepted this cycle.
    assign signed_op = ~bus.funct3[0];
    assign a_neg     = signed_op & bus.a[XLEN-1];
    assign b_neg     = signed_op & bus.b[XLEN-1];
    assign abs_a     = a_neg ? -bus.a : bus.a;
    assign abs_b     = b_neg ? -bus.b : bus.b;
    assign is_zero   = (bus.b == '0);
    assign is_ovf    = signed_op & (bus.a == SMIN) & (bus.b == ONES);
    assign special   = is_zero | is_ovf;
    assign special_y = is_zero ? (bus.funct3[1] ? bus.a : ONES)
                               : (bus.funct3[1] ? '0 : SMIN);
    assign accept    = bus.start & bus.funct3[2];

    div_step #(.W(XLEN)) u_step (
        .rem      (rem),
        .q_msb    (quo[XLEN-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (accept) begin
                        if (special) begin
                            y     <= special_y;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo     <= abs_a;
                            rem     <= '0;
                            divisor <= abs_b;
                            op_rem  <= bus.funct3[1];
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo   <= {quo[XLEN-2:0], q_bit};
                    rem   <= rem_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    // Quotient sign from operand signs; remainder follows the dividend.
                    if (op_rem) begin
                        y <= neg_r ? -rem : rem;
                    end else begin
                        y <= neg_q ? -quo : quo;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.y     = y;
    assign bus.stall = busy | (bus.start & (state == IDLE));
endmodule

// File: tb/tb_div_seq.sv
// Randomised and directed checks of div_seq against a cycle-level behavioural model.
module tb_div_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_seq_if bus();
    div_seq dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] d);
        return (d == 32'h0) || (!f3[0] && x == 32'h80000000 && d == 32'hFFFFFFFF);
    endfunction

    // RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] d);
        logic signed [31:0] sx;
        logic signed [31:0] sd;
        sx = x;
        sd = d;
        if (d == 32'h0) return f3[1] ? x : 32'hFFFFFFFF;
        if (!f3[0] && x == 32'h80000000 && d == 32'hFFFFFFFF) return f3[1] ? 32'h0 : 32'h80000000;
        if (!f3[0]) return f3[1] ? 32'(sx % sd) : 32'(sx / sd);
        return f3[1] ? (x % d) : (x / d);
    endfunction

    // Model: an accepted normal op reports done 34 cycles after acceptance.
    bit          m_valid = 1'b0;
    bit          m_active;
    bit          m_done;
    bit          m_busy;
    int          m_left;
    logic [31:0] m_res;
    logic [31:0] m_y;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_left = 0; m_y = 32'h0; m_valid = 1'b1;
        end else if (!m_valid) begin
            m_done = 1'b0;
        end else if (bus.flush) begin
            m_active = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end else if (m_active) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_y = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_res = ref_result(bus.funct3, bus.a, bus.b);
                if (is_special(bus.funct3, bus.a, bus.b)) begin
                    m_done = 1'b1; m_y = m_res;
                end else begin
                    m_active = 1'b1; m_busy = 1'b1; m_left = 33;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("done", 32'(bus.done), 32'(m_done));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("stall", 32'(bus.stall), 32'(m_busy | (bus.start & !m_active & !m_done)));
            check("y", bus.y, m_y);
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] d,
                         input bit hold, output int cyc, output logic [31:0] yv);
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.a = x; bus.b = d;
        @(posedge clk); #1;
        cyc = 1;
        got = bus.done;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (hold) begin
                bus.a = $urandom; bus.b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            got = bus.done;
        end
        check("done_timeout", 32'(got), 32'd1);
        yv = bus.y;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    int          cyc;
    logic [31:0] yv;
    bit          saw;

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = F3_DIVU; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", bus.y, 32'h0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(F3_DIVU, 32'd100, 32'd7, 1'b0, cyc, yv);
        check("divu_lat", 32'(cyc), 32'd34);
        check("divu_y", yv, 32'd14);
        idle();
        do_op(F3_REM, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, yv);
        check("rem_neg_y", yv, 32'hFFFFFFFF);
        idle();
        do_op(F3_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, yv);
        check("div_neg_y", yv, 32'hFFFFFFFD);
        idle();
        do_op(F3_DIV, 32'd5, 32'd0, 1'b0, cyc, yv);
        check("div0_lat", 32'(cyc), 32'd1);
        check("div0_y", yv, 32'hFFFFFFFF);
        idle();
        do_op(F3_REMU, 32'd5, 32'd0, 1'b0, cyc, yv);
        check("remu0_y", yv, 32'd5);
        idle();

        // Flush in cycle 10 of a DIVU 100/7.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw = 1'b1;
        end
        check("flush_nodone", 32'(saw), 32'd0);
        check("flush_y", bus.y, 32'd5);
        do_op(F3_DIVU, 32'd100, 32'd7, 1'b0, cyc, yv);
        check("post_flush_y", yv, 32'd14);
        idle();

        // Reset in cycle 20 of an op.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_y", bus.y, 32'h0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, yv);
        check("ovf_lat", 32'(cyc), 32'd1);
        check("ovf_div_y", yv, 32'h80000000);
        idle();
        do_op(F3_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, yv);
        check("ovf_rem_y", yv, 32'h0);
        idle();

        // Start held with operands changing while busy.
        do_op(F3_DIVU, 32'd100, 32'd7, 1'b1, cyc, yv);
        check("hold_lat", 32'(cyc), 32'd34);
        check("hold_y", yv, 32'd14);
        idle();

        // Back-to-back: second start issued in the DONE cycle.
        do_op(F3_DIVU, 32'd100, 32'd7, 1'b0, cyc, yv);
        do_op(F3_DIVU, 32'd9, 32'd3, 1'b0, cyc, yv);
        check("chain_lat", 32'(cyc), 32'd34);
        check("chain_y", yv, 32'd3);
        idle();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] x;
            logic [31:0] d;
            int          sel;
            f3  = 3'(4 + $urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            x   = $urandom;
            d   = $urandom;
            if (sel == 0) d = 32'h0;
            else if (sel == 1) begin x = 32'h80000000; d = 32'hFFFFFFFF; end
            else if (sel == 2) d = 32'($urandom_range(1, 20));
            else if (sel == 3) begin x = 32'($urandom_range(0, 50)); d = -32'($urandom_range(1, 9)); end
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                bus.start = 1'b1; bus.funct3 = f3; bus.a = x; bus.b = d;
                @(negedge clk);
                bus.start = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end else begin
                do_op(f3, x, d, 1'b0, cyc, yv);
                check("rand_lat", 32'(cyc), is_special(f3, x, d) ? 32'd1 : 32'd34);
                check("rand_y", yv, ref_result(f3, x, d));
                idle();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
